u_dadda_rca4_acc: RTL and testbench

U_DADDA_RCA4_ACC -- requirements
Module: u_dadda_rca4_acc

---
 rtl/u_dadda_rca4_acc.sv | 130 +++++++++++++
 tb/tb_u_dadda_rca4_acc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/u_dadda_rca4_acc.sv
// u_dadda_rca4_acc: burst accumulator for the 8-bit products of an upstream
// 4x4 multiplier. A burst of len+1 products is summed into an ACC_W-bit
// register. The sum and a sticky carry-out flag are then held until the
// consumer takes them with a valid/ready handshake.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   start, len         burst request and burst length minus one (IDLE only)
//   prod_in            8-bit product from the multiplier
//   prod_valid         handshake valid for prod_in
//   prod_ready         handshake ready for prod_in (high in ACC)
//   sum_out, ovf       accumulated sum and sticky carry-out of the burst
//   sum_valid          handshake valid for sum_out/ovf (high in DONE)
//   sum_ready          handshake ready for sum_out/ovf
//   busy               high in ACC and DONE
module u_dadda_rca4_acc #(
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       len,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reset asserts immediately and releases on a clean clk edge.
    logic [1:0] rst_sync;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end

    assign rst_int = rst_sync[1];

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [SUM_W-1:0]   sum_ext;
    logic               prod_ready_q, sum_valid_q, busy_q;

    // State and datapath registers; handshake outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            sum_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= (state_d == ACC);
            sum_valid_q  <= (state_d == DONE);
            busy_q       <= (state_d != IDLE);
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // One extra bit captures the carry-out of the modulo-2^ACC_W add.
        sum_ext = {1'b0, acc_q} + SUM_W'(prod_in);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    cnt_d   = len;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ACC: begin
                if (prod_valid && prod_ready_q) begin
                    acc_d = sum_ext[ACC_W-1:0];
                    ovf_d = ovf_q | sum_ext[ACC_W];
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (sum_valid_q && sum_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign prod_ready = prod_ready_q;
    assign sum_valid  = sum_valid_q;
    assign busy       = busy_q;
    assign sum_out    = acc_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_u_dadda_rca4_acc.sv
// Directed bench for u_dadda_rca4_acc. A 12-bit and an 8-bit instance share
// every input. The 8-bit instance is checked only in the overflow scenario.
module tb_u_dadda_rca4_acc;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  len;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        sum_ready;

    logic        prod_ready12, sum_valid12, ovf12, busy12;
    logic [11:0] sum12;
    logic        prod_ready8, sum_valid8, ovf8, busy8;
    logic [7:0]  sum8;

    int n_vec;
    int n_err;
    int exp_sum;

    u_dadda_rca4_acc #(.ACC_W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready12),
        .sum_out(sum12), .sum_valid(sum_valid12), .sum_ready(sum_ready),
        .ovf(ovf12), .busy(busy12)
    );

    u_dadda_rca4_acc #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready8),
        .sum_out(sum8), .sum_valid(sum_valid8), .sum_ready(sum_ready),
        .ovf(ovf8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_burst(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] p);
        prod_in    = p;
        prod_valid = 1'b1;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic handshake();
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; len = 4'd0; prod_in = 8'd0;
        prod_valid = 1'b0; sum_ready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_sum", 32'(sum12), 32'd0);
        chk("rst_valid", 32'(sum_valid12), 32'd0);
        chk("rst_ready", 32'(prod_ready12), 32'd0);
        chk("rst_busy", 32'(busy12), 32'd0);
        chk("rst_ovf", 32'(ovf12), 32'd0);

        rst = 1'b0;
        tick(); tick(); tick();

        // IDLE ignores prod_valid
        feed(8'd33);
        chk("idle_ready", 32'(prod_ready12), 32'd0);
        chk("idle_busy", 32'(busy12), 32'd0);

        // Single product
        start_burst(4'd0);
        chk("single_ready", 32'(prod_ready12), 32'd1);
        chk("single_busy", 32'(busy12), 32'd1);
        feed(8'd225);
        chk("single_valid", 32'(sum_valid12), 32'd1);
        chk("single_sum", 32'(sum12), 32'd225);
        chk("single_ovf", 32'(ovf12), 32'd0);
        chk("single_pr_done", 32'(prod_ready12), 32'd0);
        handshake();
        chk("single_idle_valid", 32'(sum_valid12), 32'd0);
        chk("single_idle_busy", 32'(busy12), 32'd0);
        chk("single_idle_hold", 32'(sum12), 32'd225);

        // Full burst with gaps; start pulses inside ACC must be ignored
        start_burst(4'd15);
        exp_sum = 0;
        for (int i = 0; i < 16; i++) begin
            if ((i % 3) == 1) begin
                start = 1'b1;
                len   = 4'd0;
                tick();
                start = 1'b0;
                chk("burst_gap_sum", 32'(sum12), 32'(exp_sum));
                chk("burst_gap_ready", 32'(prod_ready12), 32'd1);
            end
            chk("burst_no_early_valid", 32'(sum_valid12), 32'd0);
            feed(8'd225);
            exp_sum += 225;
            if (i < 15) begin
                chk("burst_ready", 32'(prod_ready12), 32'd1);
                chk("burst_partial", 32'(sum12), 32'(exp_sum));
            end
        end
        chk("burst_valid", 32'(sum_valid12), 32'd1);
        chk("burst_sum", 32'(sum12), 32'd3600);
        chk("burst_ovf", 32'(ovf12), 32'd0);
        handshake();
        chk("burst_idle", 32'(sum_valid12), 32'd0);

        // Back-to-back: start right after the handshake; overflow on 8-bit instance
        start_burst(4'd1);
        chk("b2b_accepted", 32'(prod_ready12), 32'd1);
        feed(8'd200);
        feed(8'd100);
        chk("ovf8_valid", 32'(sum_valid8), 32'd1);
        chk("ovf8_sum", 32'(sum8), 32'd44);
        chk("ovf8_ovf", 32'(ovf8), 32'd1);
        chk("ovf12_sum", 32'(sum12), 32'd300);
        chk("ovf12_ovf", 32'(ovf12), 32'd0);

        // Backpressure in DONE while toggling start and prod_valid
        for (int i = 0; i < 5; i++) begin
            start      = (i % 2) == 0;
            prod_valid = (i % 2) == 1;
            prod_in    = 8'd77;
            len        = 4'd3;
            tick();
            chk("bp_sum", 32'(sum12), 32'd300);
            chk("bp_valid", 32'(sum_valid12), 32'd1);
            chk("bp_ready", 32'(prod_ready12), 32'd0);
            chk("bp_ovf8", 32'(ovf8), 32'd1);
        end
        start = 1'b0;
        prod_valid = 1'b0;
        handshake();
        chk("bp_release_valid", 32'(sum_valid12), 32'd0);
        chk("bp_release_busy", 32'(busy12), 32'd0);
        chk("bp_release_hold", 32'(sum12), 32'd300);

        // Reset mid-burst
        start_burst(4'd7);
        feed(8'd10);
        feed(8'd20);
        feed(8'd30);
        chk("mid_partial", 32'(sum12), 32'd60);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_sum", 32'(sum12), 32'd0);
        chk("mid_rst_ready", 32'(prod_ready12), 32'd0);
        chk("mid_rst_busy", 32'(busy12), 32'd0);
        chk("mid_rst_valid", 32'(sum_valid12), 32'd0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("post_rst_idle", 32'(busy12), 32'd0);
        start_burst(4'd0);
        feed(8'd9);
        chk("post_rst_valid", 32'(sum_valid12), 32'd1);
        chk("post_rst_sum", 32'(sum12), 32'd9);
        chk("post_rst_ovf", 32'(ovf12), 32'd0);
        handshake();

        // Every 4x4 product, one single-product burst each
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_burst(4'd0);
                feed(8'(a * b));
                chk("mul_sum", 32'(sum12), 32'(a * b));
                handshake();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
